mux_config: RTL

Byte-command configuration front end for the pin crossbar. It takes a byte stream, typically from the console UART receiver, and decodes map, enable and disable commands into a shadow table. On a COMMIT command it copies the shadow table into the live `selectors` / `enabled_out` buses that drive the crossbar, so every output changes in the same cycle. An optional readback path returns the live mapping over a response byte stream.

---
 rtl/mux_config.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mux_config.sv
// Byte-command front end for the pin crossbar: decodes MAP/ENABLE/DISABLE/CLEAR into a
// shadow table and copies it to the live buses on COMMIT. Define MUX_CONFIG_READBACK_EN to build READ.
module mux_config #(
  parameter  int INPUT_COUNT  = 16,
  parameter  int OUTPUT_COUNT = 16,
  localparam int SEL_WIDTH    = $clog2(INPUT_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [7:0]                        resp_data,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [SEL_WIDTH*OUTPUT_COUNT-1:0] selectors,
  output logic [OUTPUT_COUNT-1:0]           enabled_out,
  output logic                              err,
  output logic [7:0]                        err_count
);

  localparam logic [3:0] OP_MAP    = 4'h1;
  localparam logic [3:0] OP_ENABLE = 4'h2;
  localparam logic [3:0] OP_DIS    = 4'h3;
  localparam logic [3:0] OP_READ   = 4'h4;
  localparam logic [3:0] OP_COMMIT = 4'h5;
  localparam logic [3:0] OP_CLEAR  = 4'h6;

`ifdef MUX_CONFIG_READBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_ARG, S_RESP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ARG} state_t;
`endif

  typedef logic [OUTPUT_COUNT-1:0][SEL_WIDTH-1:0] sel_tbl_t;

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  sel_tbl_t                sh_sel_q, sh_sel_d, live_sel_q, live_sel_d;
  logic [OUTPUT_COUNT-1:0] sh_en_q, sh_en_d, live_en_q, live_en_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [7:0]              resp_q, resp_d;

  logic [3:0] hdr_op, hdr_idx;
  logic       acc, idx_bad, src_bad;

  assign hdr_op  = in_data[7:4];
  assign hdr_idx = in_data[3:0];
  assign idx_bad = int'(hdr_idx) >= OUTPUT_COUNT;
  assign src_bad = int'(in_data) >= INPUT_COUNT;
  assign acc     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sh_sel_d   = sh_sel_q;
    sh_en_d    = sh_en_q;
    live_sel_d = live_sel_q;
    live_en_d  = live_en_q;
    resp_d     = resp_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: if (acc) begin
        case (hdr_op)
          OP_MAP:
            if (idx_bad) err_d = 1'b1;
            else begin
              idx_d   = hdr_idx;
              state_d = S_ARG;
            end
          OP_ENABLE: if (idx_bad) err_d = 1'b1; else sh_en_d[hdr_idx] = 1'b1;
          OP_DIS:    if (idx_bad) err_d = 1'b1; else sh_en_d[hdr_idx] = 1'b0;
`ifdef MUX_CONFIG_READBACK_EN
          OP_READ:
            if (idx_bad) err_d = 1'b1;
            else begin
              resp_d  = {live_en_q[hdr_idx], 7'(live_sel_q[hdr_idx])};
              state_d = S_RESP;
            end
`endif
          OP_COMMIT: begin
            live_sel_d = sh_sel_q;
            live_en_d  = sh_en_q;
          end
          OP_CLEAR: begin
            sh_sel_d = '0;
            sh_en_d  = '0;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_ARG: if (acc) begin
        // A bad source drops the whole MAP; the shadow entry keeps its old value.
        if (src_bad) err_d = 1'b1;
        else         sh_sel_d[idx_q] = in_data[SEL_WIDTH-1:0];
        state_d = S_IDLE;
      end
`ifdef MUX_CONFIG_READBACK_EN
      S_RESP: if (resp_ready) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      sh_sel_q   <= '0;
      sh_en_q    <= '0;
      live_sel_q <= '0;
      live_en_q  <= '0;
      resp_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_sel_q   <= sh_sel_d;
      sh_en_q    <= sh_en_d;
      live_sel_q <= live_sel_d;
      live_en_q  <= live_en_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign selectors   = live_sel_q;
  assign enabled_out = live_en_q;
  assign err         = err_q;
  assign err_count   = err_cnt_q;

`ifdef MUX_CONFIG_READBACK_EN
  assign in_ready   = (state_q != S_RESP);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_q;
`else
  // Without readback the response port is inert; resp_q stays at reset.
  logic [8:0] unused_resp;
  assign unused_resp = {resp_ready, resp_q};
  assign in_ready    = 1'b1;
  assign resp_valid  = 1'b0;
  assign resp_data   = '0;
`endif

endmodule
